// File: rtl/programmable_clock_divider_pkg.sv
// rtl/programmable_clock_divider_pkg.sv - shared state encoding and ratio limits for the clock divider
package programmable_clock_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HIGH     = 2'd1,
        ST_LOW      = 2'd2,
        ST_STOPPING = 2'd3
    } state_t;

    localparam int MIN_DIV = 2;

endpackage

// File: rtl/programmable_clock_divider_phase_counter.sv
// rtl/programmable_clock_divider_phase_counter.sv - loadable down-counter with terminal-count flag
module programmable_clock_divider_phase_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_tc
);

    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - ONE_W;
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/programmable_clock_divider.sv
// rtl/programmable_clock_divider.sv - glitch-free programmable clock divider with ratio update handshake
module programmable_clock_divider
    import programmable_clock_divider_pkg::*;
#(
    parameter int DIV_WIDTH   = 8,
    parameter int DEFAULT_DIV = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 cfg_valid,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    output logic                 cfg_ready,
    output logic                 clk_div,
    output logic                 tick,
    output logic                 active,
    output logic [DIV_WIDTH-1:0] cur_div
);

    localparam logic [DIV_WIDTH-1:0] MIN_DIV_W     = DIV_WIDTH'(MIN_DIV);
    localparam logic [DIV_WIDTH-1:0] ONE_W         = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DEFAULT_DIV_W = DIV_WIDTH'(DEFAULT_DIV);

    if ((DEFAULT_DIV < MIN_DIV) || (DEFAULT_DIV >= (1 << DIV_WIDTH))) begin : g_bad_default
        $error("DEFAULT_DIV must satisfy 2 <= DEFAULT_DIV < 2**DIV_WIDTH");
    end

    state_t                 r_state, w_state_nxt;
    logic                   r_clk_div, w_clk_div_nxt;
    logic                   r_tick, w_tick_nxt;
    logic [DIV_WIDTH-1:0]   r_cur_div, w_cur_div_nxt;
    logic                   r_pend_vld, w_pend_vld_nxt;
    logic [DIV_WIDTH-1:0]   r_pend_div, w_pend_div_nxt;

    logic                   w_accept;
    logic [DIV_WIDTH-1:0]   w_cfg_clamped;
    logic [DIV_WIDTH-1:0]   w_eff_div;
    logic [DIV_WIDTH-1:0]   w_high_m1;
    logic [DIV_WIDTH-1:0]   w_low_m1;
    logic                   w_tc;
    logic                   w_boundary;
    logic                   w_load;
    logic                   w_dec;
    logic [DIV_WIDTH-1:0]   w_load_val;

    assign w_accept      = cfg_valid && !r_pend_vld;
    assign w_cfg_clamped = (cfg_div < MIN_DIV_W) ? MIN_DIV_W : cfg_div;
    // A ratio handed over on the boundary cycle itself bypasses the pending slot.
    assign w_eff_div     = r_pend_vld ? r_pend_div : (w_accept ? w_cfg_clamped : r_cur_div);
    assign w_high_m1     = (w_eff_div - ONE_W) >> 1;
    assign w_low_m1      = (r_cur_div >> 1) - ONE_W;
    assign w_boundary    = (r_state == ST_IDLE) || (w_tc && !r_clk_div);

    programmable_clock_divider_phase_counter #(
        .WIDTH (DIV_WIDTH)
    ) u_phase_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_dec      (w_dec),
        .i_load_val (w_load_val),
        .o_tc       (w_tc)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_clk_div_nxt  = r_clk_div;
        w_tick_nxt     = 1'b0;
        w_cur_div_nxt  = r_cur_div;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_div_nxt = r_pend_div;
        w_load         = 1'b0;
        w_dec          = 1'b0;
        w_load_val     = '0;

        if (w_boundary) begin
            w_cur_div_nxt  = w_eff_div;
            w_pend_vld_nxt = 1'b0;
        end else if (w_accept) begin
            w_pend_vld_nxt = 1'b1;
            w_pend_div_nxt = w_cfg_clamped;
        end

        if (r_state == ST_IDLE) begin
            if (enable) begin
                w_state_nxt   = ST_HIGH;
                w_clk_div_nxt = 1'b1;
                w_tick_nxt    = 1'b1;
                w_load        = 1'b1;
                w_load_val    = w_high_m1;
            end
        end else if (!w_tc) begin
            w_dec       = 1'b1;
            w_state_nxt = !enable ? ST_STOPPING : (r_clk_div ? ST_HIGH : ST_LOW);
        end else if (r_clk_div) begin
            w_clk_div_nxt = 1'b0;
            w_load        = 1'b1;
            w_load_val    = w_low_m1;
            w_state_nxt   = enable ? ST_LOW : ST_STOPPING;
        end else if (enable) begin
            w_state_nxt   = ST_HIGH;
            w_clk_div_nxt = 1'b1;
            w_tick_nxt    = 1'b1;
            w_load        = 1'b1;
            w_load_val    = w_high_m1;
        end else begin
            w_state_nxt   = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_clk_div  <= 1'b0;
            r_tick     <= 1'b0;
            r_cur_div  <= DEFAULT_DIV_W;
            r_pend_vld <= 1'b0;
            r_pend_div <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clk_div  <= w_clk_div_nxt;
            r_tick     <= w_tick_nxt;
            r_cur_div  <= w_cur_div_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_pend_div <= w_pend_div_nxt;
        end
    end

    assign cfg_ready = !r_pend_vld;
    assign clk_div   = r_clk_div;
    assign tick      = r_tick;
    assign active    = (r_state != ST_IDLE);
    assign cur_div   = r_cur_div;

endmodule

// File: doc/programmable_clock_divider.md
PROGRAMMABLE_CLOCK_DIVIDER -- requirements
Module: programmable_clock_divider

Interface
REQ-001 Parameter DIV_WIDTH, default 8: width of the divide-ratio field.
REQ-002 Parameter DEFAULT_DIV, default 128: divide ratio after reset; SHALL satisfy 2 <= DEFAULT_DIV < 2^DIV_WIDTH, else elaboration error.
REQ-003 clk  input  1  single clock; all logic posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  run request; level-sensitive.
REQ-006 cfg_valid  input  1  new divide ratio offered.
REQ-007 cfg_div  input  DIV_WIDTH  offered divide ratio N (output period in clk cycles).
REQ-008 cfg_ready  output  1  ratio update can be accepted; transfer when cfg_valid && cfg_ready.
REQ-009 clk_div  output  1  registered divided clock.
REQ-010 tick  output  1  one-cycle pulse coincident with each clk_div rising edge.
REQ-011 active  output  1  high whenever state != IDLE.
REQ-012 cur_div  output  DIV_WIDTH  ratio governing the current (or next, when idle) period.

Function
REQ-013 States: IDLE, HIGH, LOW, STOPPING; IDLE holds clk_div=0, tick=0.
REQ-014 Ratio clamp: accepted cfg_div < 2 SHALL be stored as 2.
REQ-015 Period of N cycles: clk_div high ceil(N/2) cycles, then low floor(N/2) cycles (N=5 -> 3 high, 2 low; N=4 -> 2/2).
REQ-016 IDLE -> HIGH on the edge where enable=1 is sampled; clk_div=1 and tick=1 in the following cycle (latency 1).
REQ-017 HIGH -> LOW after ceil(N/2) high cycles; LOW -> HIGH (new period, tick=1) after floor(N/2) low cycles if enable=1.
REQ-018 enable=0 sampled in HIGH or LOW -> STOPPING; the current period completes with unchanged timing; at period end -> IDLE.
REQ-019 enable=1 re-sampled during STOPPING -> resume; next period starts exactly at the period boundary, no gap, no truncation.
REQ-020 Update handshake: one pending register; cfg_ready = !pending; accepted ratio becomes pending.
REQ-021 Pending ratio applied only at a period boundary (first cycle of the next period) or immediately on entry to/while in IDLE; clk_div never shows a truncated or extended phase.
REQ-022 Handshake in the last cycle of a period: new ratio governs the very next period; cfg_ready low for at most that cycle.
REQ-023 cur_div SHALL update in the same cycle the new ratio takes effect.
REQ-024 Counter width DIV_WIDTH; no wrap possible since phase lengths < 2^DIV_WIDTH.
REQ-025 N=2: clk_div toggles every cycle, tick every second cycle.
REQ-026 N = 2^DIV_WIDTH-1: correct 128/127 split at defaults width (255 -> 128 high, 127 low).

Reset
REQ-027 On rst sampled high: state IDLE, clk_div=0, tick=0, active=0, pending cleared, cfg_ready=1, cur_div=DEFAULT_DIV, counter 0.
REQ-028 Reset mid-period SHALL abort immediately; outputs reach reset values in the cycle after rst is sampled; enable sampled in that same cycle is ignored.

Structure
REQ-029 Shared package holds state encoding typedef and constant MIN_DIV=2.
REQ-030 One natural sub-module: programmable_clock_divider_phase_counter (loadable down-counter with terminal-count flag).
REQ-031 clk_div and tick SHALL be flop outputs, no combinational path from inputs.

Verification
REQ-032 Reset, enable=1, N=128 -> first tick 1 cycle after enable sampled; clk_div 64 high / 64 low, ticks every 128 cycles.
REQ-033 cfg_div=5 while running N=4 -> current 2/2 period completes, next period 3 high / 2 low; cur_div changes at that boundary.
REQ-034 cfg_div=0 and cfg_div=1 -> behave as N=2 (alternating 1/0, tick every 2 cycles).
REQ-035 enable dropped mid-HIGH at N=6 -> remaining high cycles, 3 low cycles, then IDLE, active=0; re-enable in STOPPING -> next tick exactly 6 cycles after previous.
REQ-036 Two back-to-back cfg_valid -> second held off (cfg_ready=0) until first applied; both ratios applied in order on consecutive boundaries.
REQ-037 rst asserted mid-LOW with pending update -> next cycle clk_div=0, active=0, cur_div=128, cfg_ready=1, pending dropped.
